// File: rtl/gpio_in_ip_if.sv
// Register bus for gpio_in_ip: one-cycle wr_en/rd_en strobes, 2-bit word
// address, 32-bit write data and registered read data.
interface gpio_in_ip_if;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wr_en, output rd_en, output addr, output wdata, input rdata);
  modport slave  (input wr_en, input rd_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_in_ip.sv
// Memory-mapped GPIO input port: synchronizer, optional debounce
// (GPIO_IN_DEBOUNCE_EN), per-pin edge detect, W1C status and level irq.
module gpio_in_ip #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             resetn,
  gpio_in_ip_if.slave      bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_IRQ_EN   = 2'd1,
    ADDR_EDGE_SEL = 2'd2,
    ADDR_STATUS   = 2'd3
  } reg_addr_e;

  // Arming also covers the debounce latency so pins high through reset stay quiet.
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int unsigned ARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
`else
  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
`endif
  localparam int unsigned AW = $clog2(ARM_CYCLES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] events;
  logic [AW-1:0]    arm_q, arm_d;
  logic             armed;
  logic [31:0]      rdata_q, rdata_d;
  reg_addr_e        addr;

  assign addr   = reg_addr_e'(bus.addr);
  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = gpio_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;

  // Accept synced on the D-th consecutive differing edge; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (synced[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = synced[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign filtered = filt_q;
`else
  assign filtered = synced;
`endif

  assign armed  = (arm_q == AW'(ARM_CYCLES));
  assign events = armed ? (( filtered & ~prev_q & ~edge_sel_q) |
                           (~filtered &  prev_q &  edge_sel_q)) : '0;

  always_comb begin
    prev_d     = filtered;
    arm_d      = armed ? arm_q : arm_q + 1'b1;
    irq_en_d   = irq_en_q;
    edge_sel_d = edge_sel_q;
    status_d   = status_q;
    rdata_d    = rdata_q;

    if (bus.wr_en) begin
      case (addr)
        ADDR_IRQ_EN:   irq_en_d   = bus.wdata[WIDTH-1:0];
        ADDR_EDGE_SEL: edge_sel_d = bus.wdata[WIDTH-1:0];
        ADDR_STATUS:   status_d   = status_q & ~bus.wdata[WIDTH-1:0];
        default:       ;
      endcase
    end
    // New events override a same-cycle clear.
    status_d = status_d | events;

    if (bus.rd_en) begin
      rdata_d = '0;
      case (addr)
        ADDR_DATA:     rdata_d[WIDTH-1:0] = filtered;
        ADDR_IRQ_EN:   rdata_d[WIDTH-1:0] = irq_en_q;
        ADDR_EDGE_SEL: rdata_d[WIDTH-1:0] = edge_sel_q;
        ADDR_STATUS:   rdata_d[WIDTH-1:0] = status_q;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q     <= '0;
      arm_q      <= '0;
      irq_en_q   <= '0;
      edge_sel_q <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q     <= prev_d;
      arm_q      <= arm_d;
      irq_en_q   <= irq_en_d;
      edge_sel_q <= edge_sel_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign irq       = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_in_ip.sv
// Directed self-checking bench for gpio_in_ip (S=2, D=4); debounce cases
// are compiled in with GPIO_IN_DEBOUNCE_EN.
module tb_gpio_in_ip;

  localparam int unsigned S = 2;
  localparam int unsigned D = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int unsigned LAT = S + D;
`else
  localparam int unsigned LAT = S;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] gpio_in = '0;
  logic        irq;
  logic [31:0] rd_val;
  int          checks = 0;
  int          errors = 0;

  gpio_in_ip_if bus ();

  gpio_in_ip #(
    .WIDTH           (32),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .gpio_in (gpio_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    tick(1);
    bus.rd_en = 1'b0;
    d = bus.rdata;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Pins high through reset, arming must hide the apparent rising edge
    gpio_in = 32'hFFFF_FFFF;
    tick(3);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    resetn = 1'b1;
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'h0);
    tick(LAT - S);
    rd(2'd0, rd_val); check("boot_data", rd_val, 32'hFFFF_FFFF);
    rd(2'd1, rd_val); check("boot_irq_en", rd_val, 32'hFFFF_FFFF);
    rd(2'd2, rd_val); check("boot_edge_sel", rd_val, 32'h0);
    rd(2'd3, rd_val); check("boot_status", rd_val, 32'h0);
    check("boot_irq", {31'b0, irq}, 32'h0);
    tick(1);
    check("rdata_hold", bus.rdata, 32'h0);

    // Falling pins with rising selected raise nothing
    gpio_in = 32'h0;
    tick(LAT + 2);
    rd(2'd3, rd_val); check("fall_unsel", rd_val, 32'h0);

    // Rising edge on pin 0
    wr(2'd1, 32'h1);
    gpio_in[0] = 1'b1;
    tick(LAT);
    check("rise_irq_early", {31'b0, irq}, 32'h0);
    tick(1);
    check("rise_irq", {31'b0, irq}, 32'h1);
    rd(2'd3, rd_val); check("rise_status", rd_val, 32'h1);
    wr(2'd3, 32'h1);
    check("w1c_irq", {31'b0, irq}, 32'h0);
    rd(2'd3, rd_val); check("w1c_status", rd_val, 32'h0);

    // Falling select on pin 5 with irq masked
    wr(2'd2, 32'h20);
    wr(2'd1, 32'h0);
    gpio_in[5] = 1'b1;
    tick(LAT + 1);
    gpio_in[5] = 1'b0;
    tick(LAT + 1);
    rd(2'd3, rd_val); check("fall_status", rd_val, 32'h20);
    check("fall_masked_irq", {31'b0, irq}, 32'h0);
    wr(2'd1, 32'h20);
    check("fall_enable_irq", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h20);
    check("fall_clear_irq", {31'b0, irq}, 32'h0);

    // W1C coinciding with a new event on bit 3
    wr(2'd1, 32'h08);
    gpio_in[3] = 1'b1;
    tick(LAT + 1);
    check("b3_first_irq", {31'b0, irq}, 32'h1);
    gpio_in[3] = 1'b0;
    tick(LAT + 1);
    gpio_in[3] = 1'b1;
    tick(LAT);
    wr(2'd3, 32'h08);
    check("b3_setwins_irq", {31'b0, irq}, 32'h1);
    rd(2'd3, rd_val); check("b3_setwins_status", rd_val, 32'h08);
    rd(2'd0, rd_val); check("data_pins", rd_val, 32'h09);

    // Read and write of the same address in one cycle
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.addr  = 2'd1;
    bus.wdata = 32'hAA;
    tick(1);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("rdwr_old", bus.rdata, 32'h08);
    rd(2'd1, rd_val); check("rdwr_new", rd_val, 32'hAA);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, rd_val); check("data_ro", rd_val, 32'h09);
    check("irq_en_aa", {31'b0, irq}, 32'h1);

`ifdef GPIO_IN_DEBOUNCE_EN
    // A 3-cycle glitch is filtered, a 4-cycle-stable level is accepted
    gpio_in[2] = 1'b1;
    tick(3);
    gpio_in[2] = 1'b0;
    tick(10);
    rd(2'd0, rd_val); check("glitch_data", rd_val, 32'h09);
    rd(2'd3, rd_val); check("glitch_status", rd_val, 32'h08);
    gpio_in[2] = 1'b1;
    tick(6);
    rd(2'd3, rd_val); check("deb_status_early", rd_val, 32'h08);
    rd(2'd3, rd_val); check("deb_status", rd_val, 32'h0C);
    rd(2'd0, rd_val); check("deb_data", rd_val, 32'h0D);
`endif

    // Asynchronous reset between clock edges while filters are busy
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, rd_val); check("pre_reset_rdata", rd_val, 32'hFFFF_FFFF);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    gpio_in[7] = 1'b1;
    tick(2);
    #2;
    resetn = 1'b0;
    #1;
    check("async_irq", {31'b0, irq}, 32'h0);
    check("async_rdata", bus.rdata, 32'h0);
    tick(2);
    resetn = 1'b1;
    rd(2'd1, rd_val); check("post_irq_en", rd_val, 32'h0);
    rd(2'd2, rd_val); check("post_edge_sel", rd_val, 32'h0);
    rd(2'd3, rd_val); check("post_status", rd_val, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
